// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline stages.
// Opcodes, NOP encoding and the fetch FSM state type.
package riscv_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD,
        S_DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Static pre-decode of B/J immediates for fetch-stage prediction.
// Optional macro FETCH_BTFN_PREDICT_EN: backward branches predicted taken.
module fetch_predecode
    import riscv_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] instr_i,
    output logic [DW-1:0] imm_ext_o,
    output logic          pred_taken_o
);

    logic is_jal;
    logic is_br;
    logic [DW-1:0] imm_j;
    logic [DW-1:0] imm_b;

    assign is_jal = (instr_i[6:0] == OPC_JAL);
    assign is_br  = (instr_i[6:0] == OPC_BRANCH);

    assign imm_j = {{(DW-20){instr_i[31]}}, instr_i[19:12],
                    instr_i[20], instr_i[30:21], 1'b0};
    assign imm_b = {{(DW-12){instr_i[31]}}, instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};

    always_comb begin
        imm_ext_o    = '0;
        pred_taken_o = 1'b0;
        unique case (1'b1)
            is_jal: begin
                imm_ext_o    = imm_j;
                pred_taken_o = 1'b1;
            end
            is_br: begin
                imm_ext_o = imm_b;
`ifdef FETCH_BTFN_PREDICT_EN
                pred_taken_o = instr_i[31];
`else
                pred_taken_o = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem fetch.
// Optional macro FETCH_BTFN_PREDICT_EN enables backward-taken prediction.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int          DW       = 32,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_f_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    input  logic          trap_i,
    input  logic [DW-1:0] trap_pc_i,
    output logic          imem_req_o,
    output logic [DW-1:0] imem_addr_o,
    input  logic [DW-1:0] imem_rdata_i,
    input  logic          imem_valid_i,
    output logic [DW-1:0] instr_f_o,
    output logic [DW-1:0] pc_f_o,
    output logic [DW-1:0] pc_plus_4_f_o,
    output logic [DW-1:0] imm_ext_f_o,
    output logic          pred_taken_o,
    output logic          fetch_valid_o,
    output logic          imem_wait_o
);

    fetch_state_t state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] buf_q, buf_d;

    logic          jump;
    logic [DW-1:0] jump_pc;
    logic [DW-1:0] pc_seq;

    assign jump    = trap_i | redirect_i;
    assign jump_pc = trap_i ? {trap_pc_i[DW-1:2], 2'b00}
                            : {redirect_pc_i[DW-1:2], 2'b00};

    assign imem_addr_o   = pc_q;
    assign pc_f_o        = pc_q;
    assign pc_plus_4_f_o = pc_q + DW'(4);

    // Fetch outputs are combinational so a zero-wait memory sustains 1 IPC.
    always_comb begin
        imem_req_o    = 1'b0;
        imem_wait_o   = 1'b0;
        fetch_valid_o = 1'b0;
        instr_f_o     = DW'(NOP_INSTR);
        unique case (state_q)
            S_BOOT: ;
            S_FETCH: begin
                imem_req_o  = 1'b1;
                imem_wait_o = ~imem_valid_i;
                if (imem_valid_i && !jump) begin
                    fetch_valid_o = 1'b1;
                    instr_f_o     = imem_rdata_i;
                end
            end
            S_HOLD: begin
                if (!jump) begin
                    fetch_valid_o = 1'b1;
                    instr_f_o     = buf_q;
                end
            end
            S_DROP: begin
                imem_req_o  = 1'b1;
                imem_wait_o = 1'b1;
            end
            default: ;
        endcase
    end

    fetch_predecode #(
        .DW           (DW)
    ) u_predecode (
        .instr_i      (instr_f_o),
        .imm_ext_o    (imm_ext_f_o),
        .pred_taken_o (pred_taken_o)
    );

    assign pc_seq = pred_taken_o ? pc_q + imm_ext_f_o : pc_q + DW'(4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (jump) begin
                    pc_d    = jump_pc;
                    state_d = imem_valid_i ? S_FETCH : S_DROP;
                end else if (imem_valid_i) begin
                    if (stall_f_i) begin
                        buf_d   = imem_rdata_i;
                        state_d = S_HOLD;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            S_HOLD: begin
                if (jump) begin
                    pc_d    = jump_pc;
                    state_d = S_FETCH;
                end else if (!stall_f_i) begin
                    pc_d    = pc_seq;
                    state_d = S_FETCH;
                end
            end
            S_DROP: begin
                if (jump) begin
                    pc_d = jump_pc;
                end else if (imem_valid_i) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            buf_q   <= DW'(NOP_INSTR);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Honours FETCH_BTFN_PREDICT_EN for the backward-branch expectations.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_f_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic [31:0] trap_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_valid_i;
    logic [31:0] instr_f_o;
    logic [31:0] pc_f_o;
    logic [31:0] pc_plus_4_f_o;
    logic [31:0] imm_ext_f_o;
    logic        pred_taken_o;
    logic        fetch_valid_o;
    logic        imem_wait_o;

    logic        auto_m;
    logic        man_valid;
    logic [31:0] man_rdata;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h40:         mem_rd = 32'hFE00_08E3;
            32'h30, 32'h44: mem_rd = 32'h0100_006F;
            default:        mem_rd = 32'h0000_0013;
        endcase
    endfunction

    assign imem_valid_i = auto_m ? imem_req_o : man_valid;
    assign imem_rdata_i = auto_m ? mem_rd(imem_addr_o) : man_rdata;

    fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_f_i     (stall_f_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .trap_i        (trap_i),
        .trap_pc_i     (trap_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .imem_valid_i  (imem_valid_i),
        .instr_f_o     (instr_f_o),
        .pc_f_o        (pc_f_o),
        .pc_plus_4_f_o (pc_plus_4_f_o),
        .imm_ext_f_o   (imm_ext_f_o),
        .pred_taken_o  (pred_taken_o),
        .fetch_valid_o (fetch_valid_o),
        .imem_wait_o   (imem_wait_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_br_next;
    logic [31:0] exp_br_pred;
    logic [31:0] exp_jal_next;

    initial begin
`ifdef FETCH_BTFN_PREDICT_EN
        exp_br_next  = 32'h30;
        exp_br_pred  = 32'h1;
        exp_jal_next = 32'h40;
`else
        exp_br_next  = 32'h44;
        exp_br_pred  = 32'h0;
        exp_jal_next = 32'h54;
`endif
        rst_i = 1'b1;
        stall_f_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        trap_i = 1'b0;
        trap_pc_i = '0;
        auto_m = 1'b1;
        man_valid = 1'b0;
        man_rdata = NOP_INSTR;

        #12;
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_fvalid", 32'(fetch_valid_o), 32'h0);
        chk("rst_pred", 32'(pred_taken_o), 32'h0);
        chk("rst_imm", imm_ext_f_o, 32'h0);
        chk("rst_instr", instr_f_o, 32'h13);
        chk("rst_pc", pc_f_o, 32'h0);
        chk("rst_pc4", pc_plus_4_f_o, 32'h4);
        chk("rst_wait", 32'(imem_wait_o), 32'h0);

        @(negedge clk_i); rst_i = 1'b0; #1;
        chk("boot_req", 32'(imem_req_o), 32'h0);
        chk("boot_fvalid", 32'(fetch_valid_o), 32'h0);

        @(negedge clk_i); #1;
        chk("zw_addr0", imem_addr_o, 32'h0);
        chk("zw_req", 32'(imem_req_o), 32'h1);
        chk("zw_fvalid", 32'(fetch_valid_o), 32'h1);
        @(negedge clk_i); #1;
        chk("zw_addr4", imem_addr_o, 32'h4);
        @(negedge clk_i); #1;
        chk("zw_addr8", imem_addr_o, 32'h8);

        @(negedge clk_i); auto_m = 1'b0; man_valid = 1'b0; #1;
        chk("late_addr", imem_addr_o, 32'hC);
        chk("late_wait1", 32'(imem_wait_o), 32'h1);
        chk("late_fv0", 32'(fetch_valid_o), 32'h0);
        @(negedge clk_i); #1;
        chk("late_wait2", 32'(imem_wait_o), 32'h1);
        chk("late_hold", imem_addr_o, 32'hC);
        @(negedge clk_i); man_valid = 1'b1; man_rdata = NOP_INSTR; #1;
        chk("late_wait0", 32'(imem_wait_o), 32'h0);
        chk("late_fv1", 32'(fetch_valid_o), 32'h1);
        chk("late_pc", pc_f_o, 32'hC);

        @(negedge clk_i);
        man_rdata = 32'h0050_0093; stall_f_i = 1'b1; #1;
        chk("stl_fv", 32'(fetch_valid_o), 32'h1);
        chk("stl_instr", instr_f_o, 32'h0050_0093);
        chk("stl_pc4", pc_plus_4_f_o, 32'h14);
        @(negedge clk_i); man_valid = 1'b0; #1;
        chk("hold_req", 32'(imem_req_o), 32'h0);
        chk("hold_instr", instr_f_o, 32'h0050_0093);
        chk("hold_pc", pc_f_o, 32'h10);
        @(negedge clk_i); stall_f_i = 1'b0; #1;
        chk("rel_fv", 32'(fetch_valid_o), 32'h1);
        chk("rel_pc", pc_f_o, 32'h10);
        @(negedge clk_i); #1;
        chk("rel_next", imem_addr_o, 32'h14);
        chk("rel_req", 32'(imem_req_o), 32'h1);

        redirect_i = 1'b1; redirect_pc_i = 32'h107; #1;
        chk("rd_fv", 32'(fetch_valid_o), 32'h0);
        @(negedge clk_i); redirect_i = 1'b0; #1;
        chk("drop_req", 32'(imem_req_o), 32'h1);
        chk("drop_wait", 32'(imem_wait_o), 32'h1);
        chk("drop_addr", imem_addr_o, 32'h104);
        @(negedge clk_i);
        man_valid = 1'b1; man_rdata = 32'h0050_0093; #1;
        chk("drop_fv", 32'(fetch_valid_o), 32'h0);
        chk("drop_wait2", 32'(imem_wait_o), 32'h1);
        @(negedge clk_i); man_valid = 1'b0; #1;
        chk("rd_addr", imem_addr_o, 32'h104);
        chk("rd_req", 32'(imem_req_o), 32'h1);

        @(negedge clk_i);
        man_valid = 1'b1; man_rdata = NOP_INSTR;
        trap_i = 1'b1; trap_pc_i = 32'h200;
        redirect_i = 1'b1; redirect_pc_i = 32'h300; #1;
        chk("trap_fv", 32'(fetch_valid_o), 32'h0);
        @(negedge clk_i);
        trap_i = 1'b0; redirect_i = 1'b0; man_valid = 1'b0; #1;
        chk("trap_addr", imem_addr_o, 32'h200);

        redirect_i = 1'b1; redirect_pc_i = 32'h40; man_valid = 1'b1;
        @(negedge clk_i); redirect_i = 1'b0; auto_m = 1'b1; #1;
        chk("br_addr", imem_addr_o, 32'h40);
        chk("br_instr", instr_f_o, 32'hFE00_08E3);
        chk("br_imm", imm_ext_f_o, 32'hFFFF_FFF0);
        chk("br_pred", 32'(pred_taken_o), exp_br_pred);
        @(negedge clk_i); #1;
        chk("br_next", imem_addr_o, exp_br_next);
        chk("jal_imm", imm_ext_f_o, 32'h10);
        chk("jal_pred", 32'(pred_taken_o), 32'h1);
        @(negedge clk_i); #1;
        chk("jal_next", imem_addr_o, exp_jal_next);

        auto_m = 1'b0; man_valid = 1'b1; man_rdata = NOP_INSTR;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        @(negedge clk_i); redirect_i = 1'b0; auto_m = 1'b1; #1;
        chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus_4_f_o, 32'h0);
        @(negedge clk_i); #1;
        chk("wrap_next", imem_addr_o, 32'h0);

        @(negedge clk_i);
        auto_m = 1'b0; man_valid = 1'b0; rst_i = 1'b1; #1;
        chk("mrst_req", 32'(imem_req_o), 32'h0);
        chk("mrst_pc", pc_f_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0; man_valid = 1'b1; #1;
        chk("mrst_boot", 32'(imem_req_o), 32'h0);
        chk("mrst_fv", 32'(fetch_valid_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
